mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

MEM-stage data-memory access controller: the consumer of the memory-control bundle (`mem_read_flag`, `mem_write_flag`, `mem_sign_ext_flag`, `mem_sel`, `mem_write_data`) that instruction decode produces. It turns one load/store per instruction into a request/ready transaction on the data-RAM bus. It holds the pipeline through `stall_request` until the transaction completes, then returns the aligned, extended load data (or passes the ALU result through) toward WB.

## Interface
- No parameters; data and address are 32 bits, byte lanes 4.
- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous reset, active-low
- `mem_read_flag`  in  1  current instruction is a load
- `mem_write_flag`  in  1  current instruction is a store
- `mem_sign_ext_flag`  in  1  sign-extend a byte load (LB); 0 = zero-extend (LBU)
- `mem_sel`  in  4  4'b0001 byte access, 4'b1111 word access
- `mem_write_data`  in  32  store data (rt)
- `alu_result`  in  32  effective address for memory ops; result for all others
- `stall_request`  out  1  hold IF/ID/EX/MEM pipeline registers
- `result`  out  32  value forwarded to the MEM/WB register
- `ram_en`  out  1  bus request valid
- `ram_write_en`  out  4  per-byte write strobes (0 for reads)
- `ram_addr`  out  32  word-aligned address, {addr[31:2], 2'b00}
- `ram_write_data`  out  32  lane-positioned store data
- `ram_read_data`  in  32  read data, valid when `ram_ready`=1
- `ram_ready`  in  1  completes the outstanding request

## Operation
- Access = `mem_read_flag | mem_write_flag`. Both flags high is illegal and is treated as a store.
- FSM states are IDLE, BUSY, DONE.
  - IDLE: if an access is present, register the bus request and go to BUSY. Otherwise stay; `result`=`alu_result` and there is no stall.
  - BUSY: `ram_en`=1. All `ram_*` outputs are held stable from registered copies and must not track the inputs. On `ram_ready`=1, capture `ram_read_data`, drop `ram_en` at the next edge and go to DONE.
  - DONE: `result` = captured/extended load data for loads, `alu_result` for stores. `stall_request`=0. Go to IDLE unconditionally. Inputs still show the completed instruction during DONE, so the access is not re-issued.
- Byte lanes are little-endian; lane = addr[1:0].
  - Byte store: `ram_write_en` = 4'b0001 << lane; `ram_write_data` = store byte replicated on all four lanes.
  - Word store: `ram_write_en`=4'b1111; data unchanged.
  - Byte load: select `ram_read_data[8*lane+7 : 8*lane]`, then sign- or zero-extend per `mem_sign_ext_flag`.
  - Word load: full word.
  - A misaligned word access (addr[1:0]≠0) is performed on the aligned word. No exception is raised.
- `stall_request` = (IDLE && access) || BUSY. It is combinational from state and flags.
- `ram_ready` is ignored outside BUSY.

## Timing
- Reset (async, `rst`=0): state IDLE. `ram_en`=0, `ram_write_en`=0, `ram_addr`=0, `ram_write_data`=0, captured data=0. `stall_request`=0 and `result`=`alu_result` (combinational).
- Reset mid-transaction abandons the request immediately: `ram_en` falls without waiting for `ram_ready`.
- Zero-wait RAM (`ram_ready`=1 in the first BUSY cycle) follows this sequence:
  - cycle 0: IDLE, stall=1
  - cycle 1: BUSY, `ram_en`=1, ready sampled
  - cycle 2: DONE, stall=0, `result` valid
- Each access therefore costs 3 cycles, 2 of them stalled. Each extra wait cycle adds one BUSY cycle.
- Back-to-back accesses: DONE→IDLE then immediate re-issue. `ram_en` is low for at least 2 cycles between requests (DONE, IDLE).
- Non-memory instructions add zero latency and never stall.
- `ram_ready` held high continuously completes exactly one access per request and never double-issues.

## Test plan
- Reset, then ALU op `alu_result`=0x1234 with no flags → `result`=0x1234, `stall_request`=0, `ram_en`=0 every cycle.
- SW to 0x0000_0104, data 0xDEADBEEF, ready in first BUSY cycle → `ram_addr`=0x104, `ram_write_en`=4'hF, `ram_write_data`=0xDEADBEEF. Stall high for exactly 2 cycles.
- SB at 0x0000_0203, data 0x0000_00A5 → `ram_addr`=0x200, `ram_write_en`=4'b1000, `ram_write_data`=0xA5A5A5A5.
- LB and LBU at 0x0000_0302, read data 0x11F0_2233, ready after 3 wait cycles:
  - LB → `result`=0xFFFF_FFF0; LBU → `result`=0x0000_00F0.
  - Stall lasts 5 cycles; request fields stay stable while inputs are perturbed.
- LW at 0x10 immediately followed by LW at 0x14 with zero-wait RAM → two distinct requests with `ram_en` low between them, results in order, no duplicate request.
- Assert `rst`=0 in BUSY, then pulse `ram_ready` → `ram_en`=0 at once, FSM in IDLE, the late ready is ignored, no stall after release with no flags.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MEM-stage data-memory access controller. Turns one load/store per
//   instruction into a single request/ready transaction on the data-RAM bus,
//   holds the pipeline while the transaction is outstanding, and returns the
//   lane-selected, extended load data (or the ALU result) toward WB.
//
// Ports
//   clk                in   pipeline clock
//   rst                in   asynchronous reset, active-low
//   mem_read_flag      in   instruction is a load
//   mem_write_flag     in   instruction is a store (wins if both flags set)
//   mem_sign_ext_flag  in   sign-extend a byte load (LB), else zero-extend
//   mem_sel[3:0]       in   4'b0001 byte access, 4'b1111 word access
//   mem_write_data     in   store data
//   alu_result         in   effective address for memory ops, result otherwise
//   stall_request      out  hold IF/ID/EX/MEM pipeline registers
//   result             out  value forwarded to the MEM/WB register
//   ram_en             out  bus request valid
//   ram_write_en[3:0]  out  per-byte write strobes (0 for reads)
//   ram_addr           out  word-aligned request address
//   ram_write_data     out  lane-positioned store data
//   ram_read_data      in   read data, valid with ram_ready
//   ram_ready          in   completes the outstanding request
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_flag,
    input  logic        mem_write_flag,
    input  logic        mem_sign_ext_flag,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_write_data,
    input  logic [31:0] alu_result,
    output logic        stall_request,
    output logic [31:0] result,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data,
    input  logic        ram_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic       access;
    logic       is_store;
    logic       is_byte;
    logic [1:0] lane;

    // Load attributes latched at issue so the returned data does not depend
    // on what the inputs show while the request is outstanding.
    logic        ld_p1;
    logic        ld_sext_p1;
    logic        ld_byte_p1;
    logic [1:0]  ld_lane_p1;
    logic [31:0] ld_data_p2;

    assign access   = mem_read_flag | mem_write_flag;
    // Both flags high is treated as a store.
    assign is_store = mem_write_flag;
    assign is_byte  = (mem_sel == 4'b0001);
    assign lane     = alu_result[1:0];

    function automatic logic [3:0] store_strobe(input logic byte_acc, input logic [1:0] ln);
        if (byte_acc)
            return 4'b0001 << ln;
        return 4'b1111;
    endfunction

    // A byte store drives the same byte on every lane; the strobe picks one.
    function automatic logic [31:0] store_data(input logic byte_acc, input logic [31:0] d);
        if (byte_acc)
            return {4{d[7:0]}};
        return d;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic byte_acc,
                                                input logic [1:0] ln, input logic sext);
        logic        [7:0] b;
        logic signed [7:0] bs;
        b  = word[8*ln +: 8];
        bs = b;
        if (!byte_acc)
            return word;
        if (sext)
            return 32'(bs);
        return {24'd0, b};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ram_en         <= 1'b0;
            ram_write_en   <= 4'b0000;
            ram_addr       <= 32'd0;
            ram_write_data <= 32'd0;
            ld_p1          <= 1'b0;
            ld_sext_p1     <= 1'b0;
            ld_byte_p1     <= 1'b0;
            ld_lane_p1     <= 2'd0;
            ld_data_p2     <= 32'd0;
        end else begin
            case (state)
                // Issue: request fields are registered here and then held.
                IDLE: begin
                    if (access) begin
                        ram_en         <= 1'b1;
                        ram_addr       <= {alu_result[31:2], 2'b00};
                        ram_write_en   <= is_store ? store_strobe(is_byte, lane) : 4'b0000;
                        ram_write_data <= is_store ? store_data(is_byte, mem_write_data) : 32'd0;
                        ld_p1          <= ~is_store;
                        ld_sext_p1     <= mem_sign_ext_flag;
                        ld_byte_p1     <= is_byte;
                        ld_lane_p1     <= lane;
                        state          <= BUSY;
                    end
                end
                // Outstanding: wait for ready, then capture the extended data.
                BUSY: begin
                    if (ram_ready) begin
                        ram_en       <= 1'b0;
                        ram_write_en <= 4'b0000;
                        ld_data_p2   <= extend_load(ram_read_data, ld_byte_p1, ld_lane_p1, ld_sext_p1);
                        state        <= DONE;
                    end
                end
                // Completed instruction is still on the inputs; do not re-issue.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stall_request = ((state == IDLE) && access) || (state == BUSY);
        result        = alu_result;
        if ((state == DONE) && ld_p1)
            result = ld_data_p2;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed and randomized stimulus for mem_access_ctrl, checked against a
//   behavioural model of the bus request, write strobes, lane data, load
//   extension and stall length.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic        mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data;
    logic [31:0] alu_result;
    logic        stall_request;
    logic [31:0] result;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        ram_ready;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read_flag    (mem_read_flag),
        .mem_write_flag   (mem_write_flag),
        .mem_sign_ext_flag(mem_sign_ext_flag),
        .mem_sel          (mem_sel),
        .mem_write_data   (mem_write_data),
        .alu_result       (alu_result),
        .stall_request    (stall_request),
        .result           (result),
        .ram_en           (ram_en),
        .ram_write_en     (ram_write_en),
        .ram_addr         (ram_addr),
        .ram_write_data   (ram_write_data),
        .ram_read_data    (ram_read_data),
        .ram_ready        (ram_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    function automatic logic [3:0] model_we(input bit store, input bit byte_acc, input logic [31:0] addr);
        if (!store) return 4'h0;
        if (!byte_acc) return 4'hF;
        return 4'(1 << (addr % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input bit byte_acc, input logic [31:0] d);
        if (!byte_acc) return d;
        return (d % 256) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] model_load(input bit byte_acc, input bit sext,
                                               input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        if (!byte_acc) return rd;
        v = (rd >> (8 * (addr % 4))) % 256;
        if (sext && v >= 128) return v - 32'd256;
        return v;
    endfunction

    // Non-memory instruction for one cycle; ready is noise and must be ignored.
    task automatic alu_op(input logic [31:0] v, input string tag);
        @(posedge clk); #1;
        mem_read_flag  = 1'b0;
        mem_write_flag = 1'b0;
        alu_result     = v;
        ram_ready      = 1'($urandom % 2);
        #1;
        check({tag, ".result"}, result, v);
        check({tag, ".stall"}, 32'(stall_request), 32'd0);
        check({tag, ".ram_en"}, 32'(ram_en), 32'd0);
    endtask

    // One full load/store: IDLE issue cycle, waits+1 BUSY cycles, DONE cycle.
    task automatic do_access(input bit ld, input bit byte_acc, input bit sext,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int waits,
                             input bit hold_ready, input string tag);
        int          stalls;
        logic [31:0] exp_addr;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd;
        logic [31:0] exp_res;
        exp_addr = addr & ~32'd3;
        exp_we   = model_we(!ld, byte_acc, addr);
        exp_wd   = model_wdata(byte_acc, wd);
        exp_res  = ld ? model_load(byte_acc, sext, addr, rd) : addr;

        @(posedge clk); #1;
        mem_read_flag     = ld;
        mem_write_flag    = !ld;
        mem_sign_ext_flag = sext;
        mem_sel           = byte_acc ? 4'b0001 : 4'b1111;
        mem_write_data    = wd;
        alu_result        = addr;
        ram_ready         = hold_ready;
        #1;
        stalls = 32'(stall_request);
        check({tag, ".idle_ram_en"}, 32'(ram_en), 32'd0);

        for (int i = 0; i <= waits; i++) begin
            @(posedge clk); #1;
            if (i < waits) begin
                alu_result        = $urandom;
                mem_write_data    = $urandom;
                mem_sign_ext_flag = 1'($urandom % 2);
                ram_read_data     = $urandom;
                ram_ready         = 1'b0;
            end else begin
                alu_result        = addr;
                mem_write_data    = wd;
                mem_sign_ext_flag = sext;
                ram_read_data     = rd;
                ram_ready         = 1'b1;
            end
            #1;
            stalls += 32'(stall_request);
            check($sformatf("%s.busy%0d.ram_en", tag, i), 32'(ram_en), 32'd1);
            check($sformatf("%s.busy%0d.addr", tag, i), ram_addr, exp_addr);
            check($sformatf("%s.busy%0d.we", tag, i), 32'(ram_write_en), 32'(exp_we));
            if (!ld)
                check($sformatf("%s.busy%0d.wdata", tag, i), ram_write_data, exp_wd);
        end

        @(posedge clk); #1;
        ram_ready     = hold_ready;
        ram_read_data = $urandom;
        #1;
        stalls += 32'(stall_request);
        check({tag, ".done_ram_en"}, 32'(ram_en), 32'd0);
        check({tag, ".done_result"}, result, exp_res);
        check({tag, ".stall_cycles"}, 32'(stalls), 32'(waits + 2));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst               = 1'b0;
        mem_read_flag     = 1'b0;
        mem_write_flag    = 1'b0;
        mem_sign_ext_flag = 1'b0;
        mem_sel           = 4'b1111;
        mem_write_data    = 32'd0;
        alu_result        = 32'h0000_0055;
        ram_read_data     = 32'd0;
        ram_ready         = 1'b0;
        #3;
        check("rst.ram_en", 32'(ram_en), 32'd0);
        check("rst.we", 32'(ram_write_en), 32'd0);
        check("rst.addr", ram_addr, 32'd0);
        check("rst.wdata", ram_write_data, 32'd0);
        check("rst.stall", 32'(stall_request), 32'd0);
        check("rst.result", result, 32'h0000_0055);
        @(posedge clk); #1;
        rst = 1'b1;

        // ALU ops pass through with no stall and no request
        for (int i = 0; i < 3; i++) alu_op(32'h0000_1234, "alu1234");

        // SW / SB
        do_access(1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, $urandom, 0, 1'b0, "sw");
        do_access(1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'h0000_00A5, $urandom, 0, 1'b0, "sb");

        // LB / LBU with 3 wait cycles and perturbed inputs
        do_access(1'b1, 1'b1, 1'b1, 32'h0000_0302, $urandom, 32'h11F0_2233, 3, 1'b0, "lb");
        do_access(1'b1, 1'b1, 1'b0, 32'h0000_0302, $urandom, 32'h11F0_2233, 3, 1'b0, "lbu");

        // Back-to-back LW with ready held high throughout
        do_access(1'b1, 1'b0, 1'b0, 32'h0000_0010, $urandom, $urandom, 0, 1'b1, "lw10");
        do_access(1'b1, 1'b0, 1'b0, 32'h0000_0014, $urandom, $urandom, 0, 1'b1, "lw14");
        alu_op(32'h0000_0abc, "after_lw");

        // Reset while BUSY abandons the request
        @(posedge clk); #1;
        mem_read_flag  = 1'b1;
        mem_write_flag = 1'b0;
        mem_sel        = 4'b1111;
        alu_result     = 32'h0000_0040;
        ram_ready      = 1'b0;
        @(posedge clk); #1;
        check("rstbusy.pre_ram_en", 32'(ram_en), 32'd1);
        rst = 1'b0;
        #1;
        check("rstbusy.ram_en", 32'(ram_en), 32'd0);
        check("rstbusy.addr", ram_addr, 32'd0);
        mem_read_flag = 1'b0;
        ram_ready     = 1'b1;
        ram_read_data = 32'hCAFE_F00D;
        #1;
        check("rstbusy.stall", 32'(stall_request), 32'd0);
        @(posedge clk); #1;
        ram_ready = 1'b0;
        rst       = 1'b1;
        alu_result = 32'h0000_0777;
        #1;
        check("rstrel.ram_en", 32'(ram_en), 32'd0);
        check("rstrel.stall", 32'(stall_request), 32'd0);
        check("rstrel.result", result, 32'h0000_0777);
        @(posedge clk); #1;
        ram_ready = 1'b1;
        #1;
        check("rstrel2.ram_en", 32'(ram_en), 32'd0);
        check("rstrel2.stall", 32'(stall_request), 32'd0);
        alu_op(32'h0000_0999, "rstrel3");

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            int          kind;
            int          w;
            logic [31:0] a;
            kind = int'($urandom % 6);
            w    = int'($urandom % 4);
            a    = $urandom;
            case (kind)
                0: alu_op(a, $sformatf("r%0d.alu", n));
                1: do_access(1'b1, 1'b0, 1'b0, a, $urandom, $urandom, w, 1'b0, $sformatf("r%0d.lw", n));
                2: do_access(1'b1, 1'b1, 1'b1, a, $urandom, $urandom, w, 1'b0, $sformatf("r%0d.lb", n));
                3: do_access(1'b1, 1'b1, 1'b0, a, $urandom, $urandom, w, 1'b0, $sformatf("r%0d.lbu", n));
                4: do_access(1'b0, 1'b0, 1'b0, a, $urandom, $urandom, w, 1'b0, $sformatf("r%0d.sw", n));
                default: do_access(1'b0, 1'b1, 1'b0, a, $urandom, $urandom, w, 1'b0, $sformatf("r%0d.sb", n));
            endcase
        end
        alu_op(32'h0000_0001, "final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
